// File: rtl/hwpe_ctrl_job_queue_pkg.sv
// Shared definitions for the HWPE job-queue control slave.
// Holds the register word offsets, the ACQUIRE error codes, the dispatch
// state type and a saturating counter helper.
package hwpe_ctrl_job_queue_pkg;

  // Register word offsets (add_i[4:2])
  localparam logic [2:0] JQ_TRIGGER   = 3'd0;
  localparam logic [2:0] JQ_ACQUIRE   = 3'd1;
  localparam logic [2:0] JQ_FINISHED  = 3'd2;
  localparam logic [2:0] JQ_STATUS    = 3'd3;
  localparam logic [2:0] JQ_RUNNING   = 3'd4;
  localparam logic [2:0] JQ_SOFTCLEAR = 3'd5;
  localparam logic [2:0] JQ_SWEVT     = 3'd6;

  // ACQUIRE return codes when no job slot is granted
  localparam logic [31:0] ACQUIRE_FULL   = 32'hFFFF_FFFF;
  localparam logic [31:0] ACQUIRE_LOCKED = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    StIdle,
    StStarting,
    StRun
  } jq_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_job_fifo.sv
// Owner-core FIFO for the job queue. Each entry records which core committed
// the job in that context slot; the pointers double as the register-file
// write context and the running context.
// Ports: clk_i/rst_ni clock and async reset, clear_i soft clear, push_i/data_i
// enqueue, pop_i dequeue, data_o head entry, wr_ptr_o/rd_ptr_o slot pointers,
// count_o occupancy, full_o/empty_o status.
module hwpe_ctrl_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o   = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign pop_ok   = pop_i && !empty_o;
  // A push into a full queue is allowed only when a pop frees a slot this cycle
  assign push_ok  = push_i && (!full_o || pop_ok);
  assign data_o   = mem_q[rd_ptr_q];
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/hwpe_ctrl_job_queue.sv
// HWPE control slave with an N_CONTEXT-deep FIFO job queue.
// Cores ACQUIRE a job ID (taking a lock), program the register file at
// wr_ctx_o, then commit through TRIGGER. The dispatch FSM starts queued jobs
// in order, routes job-done and auxiliary events to the owning core and
// counts finished jobs.
// Ports: periph slave (req_i/gnt_o/add_i/wen_i/data_i/id_i, r_data_o/
// r_valid_o/r_id_o), datapath handshake (done_i/evt_i/start_o/busy_o/
// clear_o), context pointers (run_ctx_o/wr_ctx_o), events (evt_o per core
// at bits [c*N_EVT +: N_EVT], sw_evt_o).
module hwpe_ctrl_job_queue
  import hwpe_ctrl_job_queue_pkg::*;
#(
  parameter int unsigned N_CORES      = 8,
  parameter int unsigned N_CONTEXT    = 4,
  parameter int unsigned N_EVT        = 4,
  parameter int unsigned N_SW_EVT     = 8,
  parameter int unsigned ID_WIDTH     = 16,
  parameter int unsigned JOB_ID_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         clear_o,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic [31:0]                  add_i,
  input  logic                         wen_i,
  input  logic [31:0]                  data_i,
  input  logic [ID_WIDTH-1:0]          id_i,
  output logic [31:0]                  r_data_o,
  output logic                         r_valid_o,
  output logic [ID_WIDTH-1:0]          r_id_o,
  input  logic                         done_i,
  input  logic [N_EVT-2:0]             evt_i,
  output logic                         start_o,
  output logic                         busy_o,
  output logic [$clog2(N_CONTEXT)-1:0] run_ctx_o,
  output logic [$clog2(N_CONTEXT)-1:0] wr_ctx_o,
  output logic [N_CORES*N_EVT-1:0]     evt_o,
  output logic [N_SW_EVT-1:0]          sw_evt_o
);

  localparam int unsigned CoreW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned CtxW  = $clog2(N_CONTEXT);

  jq_state_e                state_q, state_d;
  logic                     lock_q, lock_d;
  logic [CoreW-1:0]         lock_core_q, lock_core_d;
  logic [JOB_ID_WIDTH-1:0]  job_id_q, job_id_d;
  logic                     triggered_q, triggered_d;
  logic [31:0]              finished_q, finished_d;
  logic [2:0]               clr_cnt_q, clr_cnt_d;
  logic                     clr_fin_q;
  logic                     start_q, start_d;
  logic [N_CORES*N_EVT-1:0] evt_q, evt_d;
  logic [N_SW_EVT-1:0]      sw_evt_q, sw_evt_d;
  logic                     r_valid_q;
  logic [ID_WIDTH-1:0]      r_id_q;
  logic [31:0]              r_data_q, r_data_d;

  logic [2:0]       offset;
  logic             wr_req, rd_req, acquire, softclear_wr;
  logic [CoreW-1:0] req_core, head_core;
  logic             id_hit, is_owner, take_lock;
  logic             commit, commit_trig, done_accept, go;
  logic [31:0]      acq_data;
  logic [CtxW:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic             unused_bits;

  assign unused_bits = ^{add_i[31:5], add_i[1:0]};

  assign gnt_o     = 1'b1;
  assign r_valid_o = r_valid_q;
  assign r_id_o    = r_id_q;
  assign r_data_o  = r_data_q;
  assign start_o   = start_q;
  assign evt_o     = evt_q;
  assign sw_evt_o  = sw_evt_q;

  assign offset = add_i[4:2];
  assign wr_req = req_i && !wen_i;
  assign rd_req = req_i && wen_i;

  // Lowest set bit of the one-hot requester ID selects the core
  always_comb begin
    req_core = '0;
    for (int c = int'(N_CORES) - 1; c >= 0; c--) begin
      if (id_i[c]) req_core = CoreW'(c);
    end
  end
  assign id_hit = |id_i[N_CORES-1:0];

  // clear_o is high while the counter walks 3, 2, 1; the value 4 is the
  // one-cycle lead-in after the SOFTCLEAR write
  assign clear_o      = (clr_cnt_q != 3'd0) && (clr_cnt_q != 3'd4);
  assign softclear_wr = wr_req && (offset == JQ_SOFTCLEAR) && (clr_cnt_q == 3'd0);

  assign is_owner    = lock_q && id_hit && (lock_core_q == req_core);
  assign acquire     = rd_req && (offset == JQ_ACQUIRE);
  assign commit      = wr_req && (offset == JQ_TRIGGER) && is_owner && !fifo_full && !clear_o;
  assign commit_trig = commit && (data_i == 32'd0);
  assign done_accept = (state_q == StRun) && done_i && !clear_o;
  assign go          = (fifo_count != '0) && (triggered_q || commit_trig);

  hwpe_ctrl_job_fifo #(
    .DEPTH (N_CONTEXT),
    .WIDTH (CoreW)
  ) u_job_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_o),
    .push_i   (commit),
    .data_i   (lock_core_q),
    .pop_i    (done_accept),
    .data_o   (head_core),
    .wr_ptr_o (wr_ctx_o),
    .rd_ptr_o (run_ctx_o),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Acquire arbitration: the lock holder always sees its own job ID
  always_comb begin
    acq_data  = '0;
    take_lock = 1'b0;
    if (lock_q && !is_owner) begin
      acq_data = ACQUIRE_LOCKED;
    end else if (lock_q) begin
      acq_data[JOB_ID_WIDTH-1:0] = job_id_q;
    end else if (fifo_full) begin
      acq_data = ACQUIRE_FULL;
    end else begin
      acq_data[JOB_ID_WIDTH-1:0] = job_id_q;
      take_lock = acquire && id_hit && !clear_o;
    end
  end

  always_comb begin
    lock_d      = lock_q;
    lock_core_d = lock_core_q;
    job_id_d    = job_id_q;
    triggered_d = triggered_q;
    finished_d  = finished_q;
    clr_cnt_d   = (softclear_wr) ? 3'd4 :
                  (clr_cnt_q != 3'd0) ? clr_cnt_q - 3'd1 : 3'd0;
    if (clear_o) begin
      lock_d      = 1'b0;
      job_id_d    = '0;
      triggered_d = 1'b0;
      if (clr_fin_q) finished_d = '0;
    end else begin
      if (commit) begin
        lock_d   = 1'b0;
        job_id_d = job_id_q + JOB_ID_WIDTH'(1);
      end else if (take_lock) begin
        lock_d      = 1'b1;
        lock_core_d = req_core;
      end
      if (commit_trig) begin
        triggered_d = 1'b1;
      end else if (done_accept && !commit && (fifo_count == (CtxW + 1)'(1))) begin
        triggered_d = 1'b0;
      end
      if (done_accept) finished_d = sat_inc32(finished_q);
    end
  end

  // Dispatch FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (go) state_d = StStarting;
      StStarting: state_d = StRun;
      StRun:      if (done_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (clear_o) state_d = StIdle;
  end

  // Dispatch FSM: outputs
  always_comb begin
    busy_o  = (state_q != StIdle);
    start_d = (state_q == StStarting) && !clear_o;
  end

  always_comb begin
    evt_d = '0;
    if (!clear_o) begin
      for (int unsigned c = 0; c < N_CORES; c++) begin
        if (head_core == CoreW'(c)) begin
          evt_d[c*N_EVT]                = done_accept;
          evt_d[c*N_EVT+1 +: N_EVT-1]   = fifo_empty ? '0 : evt_i;
        end
      end
    end
  end

  always_comb begin
    sw_evt_d = '0;
    if (wr_req && (offset == JQ_SWEVT) && (int'(data_i[2:0]) < int'(N_SW_EVT))) begin
      sw_evt_d[data_i[2:0]] = 1'b1;
    end
  end

  always_comb begin
    r_data_d = '0;
    if (rd_req) begin
      case (offset)
        JQ_ACQUIRE:  r_data_d = acq_data;
        JQ_FINISHED: r_data_d = finished_q;
        JQ_STATUS: begin
          r_data_d[CtxW+1:1] = fifo_count;
          r_data_d[0]        = busy_o;
        end
        JQ_RUNNING:  r_data_d[JOB_ID_WIDTH-1:0] = job_id_q - JOB_ID_WIDTH'(fifo_count);
        default:     r_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      lock_q      <= 1'b0;
      lock_core_q <= '0;
      job_id_q    <= '0;
      triggered_q <= 1'b0;
      finished_q  <= '0;
      clr_cnt_q   <= 3'd0;
      clr_fin_q   <= 1'b0;
      start_q     <= 1'b0;
      evt_q       <= '0;
      sw_evt_q    <= '0;
      r_valid_q   <= 1'b0;
      r_id_q      <= '0;
      r_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      lock_core_q <= lock_core_d;
      job_id_q    <= job_id_d;
      triggered_q <= triggered_d;
      finished_q  <= finished_d;
      clr_cnt_q   <= clr_cnt_d;
      if (softclear_wr) clr_fin_q <= (data_i == 32'd0);
      start_q     <= start_d;
      evt_q       <= evt_d;
      sw_evt_q    <= sw_evt_d;
      r_valid_q   <= req_i;
      r_id_q      <= id_i;
      r_data_q    <= r_data_d;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_job_queue.sv
module tb_hwpe_ctrl_job_queue;
  import hwpe_ctrl_job_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] add = '0;
  logic        wen = 1'b1;
  logic [31:0] wdata = '0;
  logic [15:0] id = '0;
  logic [31:0] r_data;
  logic        r_valid;
  logic [15:0] r_id;
  logic        done = 1'b0;
  logic [2:0]  evt_in = '0;
  logic        start;
  logic        busy;
  logic [1:0]  run_ctx;
  logic [1:0]  wr_ctx;
  logic [31:0] evt;
  logic [7:0]  sw_evt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hwpe_ctrl_job_queue dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_o   (clear),
    .req_i     (req),
    .gnt_o     (gnt),
    .add_i     (add),
    .wen_i     (wen),
    .data_i    (wdata),
    .id_i      (id),
    .r_data_o  (r_data),
    .r_valid_o (r_valid),
    .r_id_o    (r_id),
    .done_i    (done),
    .evt_i     (evt_in),
    .start_o   (start),
    .busy_o    (busy),
    .run_ctx_o (run_ctx),
    .wr_ctx_o  (wr_ctx),
    .evt_o     (evt),
    .sw_evt_o  (sw_evt)
  );

  // Stimulus helpers: all called and returning on a falling edge
  task automatic bus_read(input logic [2:0] off, input int core, output logic [31:0] d);
    req = 1'b1; wen = 1'b1; add = {27'd0, off, 2'b00}; id = 16'(1) << core; wdata = '0;
    @(negedge clk);
    req = 1'b0; d = r_data;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] v, input int core);
    req = 1'b1; wen = 1'b0; add = {27'd0, off, 2'b00}; id = 16'(1) << core; wdata = v;
    @(negedge clk);
    req = 1'b0; wen = 1'b1;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; done = 1'b0; evt_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({clear, start, busy, r_valid, run_ctx, wr_ctx, evt, sw_evt, r_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got clr=%b st=%b bsy=%b rv=%b rc=%0d wc=%0d evt=%h sw=%h rd=%h expected all 0",
               clear, start, busy, r_valid, run_ctx, wr_ctx, evt, sw_evt, r_data);
    end
    vectors++;
    if (gnt !== 1'b1) begin
      miscompares++; $display("FAIL reset_gnt: got %b expected 1", gnt);
    end
  endtask

  task automatic test_single_job();
    logic [31:0] rd;
    do_reset();
    bus_read(JQ_ACQUIRE, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL single_acquire: got %h expected 00000000", rd);
    end
    vectors++;
    if (r_valid !== 1'b1 || r_id !== 16'h0001) begin
      miscompares++; $display("FAIL single_resp: got valid=%b id=%h expected 1/0001", r_valid, r_id);
    end
    bus_write(JQ_TRIGGER, 32'd0, 0);
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (start !== (k == 3)) begin
        miscompares++; $display("FAIL single_start_cycle%0d: got %b expected %b", k, start, (k == 3));
      end
      if (k == 3) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++; $display("FAIL single_busy: got %b expected 1", busy);
        end
      end
      if (k < 4) @(negedge clk);
    end
    pulse_done();
    vectors++;
    if (evt !== 32'h1) begin
      miscompares++; $display("FAIL single_evt: got %h expected 00000001", evt);
    end
    @(negedge clk);
    vectors++;
    if (evt !== 32'h0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single_after_done: got evt=%h busy=%b expected 0/0", evt, busy);
    end
    bus_read(JQ_FINISHED, 0, rd);
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++; $display("FAIL single_finished: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_fifo_order();
    logic [31:0] rd;
    bit seen;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus_read(JQ_ACQUIRE, c, rd);
      vectors++;
      if (rd !== 32'(c)) begin
        miscompares++; $display("FAIL order_acquire_core%0d: got %h expected %h", c, rd, 32'(c));
      end
      bus_write(JQ_TRIGGER, (c == 3) ? 32'd0 : 32'd1, c);
    end
    bus_read(JQ_ACQUIRE, 4, rd);
    vectors++;
    if (rd !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL order_full: got %h expected ffffffff", rd);
    end
    for (int j = 0; j < 4; j++) begin
      wait_start(seen);
      vectors++;
      if (!seen || run_ctx !== 2'(j)) begin
        miscompares++; $display("FAIL order_start%0d: got seen=%b run_ctx=%0d expected 1/%0d", j, seen, run_ctx, j);
      end
      pulse_done();
      vectors++;
      if (evt !== (32'h1 << (4 * j))) begin
        miscompares++; $display("FAIL order_evt%0d: got %h expected %h", j, evt, 32'h1 << (4 * j));
      end
    end
    bus_read(JQ_FINISHED, 0, rd);
    vectors++;
    if (rd !== 32'd4) begin
      miscompares++; $display("FAIL order_finished: got %h expected 00000004", rd);
    end
  endtask

  task automatic test_lock();
    logic [31:0] rd;
    do_reset();
    bus_read(JQ_ACQUIRE, 1, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL lock_core1: got %h expected 00000000", rd);
    end
    bus_read(JQ_ACQUIRE, 2, rd);
    vectors++;
    if (rd !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL lock_core2: got %h expected fffffffe", rd);
    end
    bus_write(JQ_TRIGGER, 32'd0, 2);
    bus_read(JQ_STATUS, 2, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL lock_foreign_commit: got %h expected 00000000", rd);
    end
    bus_read(JQ_ACQUIRE, 1, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL lock_reacquire: got %h expected 00000000", rd);
    end
    bus_write(JQ_TRIGGER, 32'd1, 1);
    bus_read(JQ_STATUS, 1, rd);
    vectors++;
    if (rd !== 32'h2) begin
      miscompares++; $display("FAIL lock_owner_commit: got %h expected 00000002", rd);
    end
  endtask

  task automatic test_commit_done();
    logic [31:0] rd;
    bit seen;
    do_reset();
    bus_read(JQ_ACQUIRE, 0, rd);
    bus_write(JQ_TRIGGER, 32'd0, 0);
    wait_start(seen);
    bus_read(JQ_ACQUIRE, 1, rd);
    bus_write(JQ_TRIGGER, 32'd1, 1);
    bus_read(JQ_ACQUIRE, 2, rd);
    vectors++;
    if (wr_ctx !== 2'd2 || run_ctx !== 2'd0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL cd_before: got wc=%0d rc=%0d busy=%b expected 2/0/1", wr_ctx, run_ctx, busy);
    end
    req = 1'b1; wen = 1'b0; add = {27'd0, JQ_TRIGGER, 2'b00}; id = 16'h0004; wdata = 32'd1;
    done = 1'b1;
    @(negedge clk);
    req = 1'b0; wen = 1'b1; done = 1'b0;
    vectors++;
    if (wr_ctx !== 2'd3 || run_ctx !== 2'd1) begin
      miscompares++; $display("FAIL cd_pointers: got wc=%0d rc=%0d expected 3/1", wr_ctx, run_ctx);
    end
    bus_read(JQ_STATUS, 0, rd);
    vectors++;
    if (rd !== 32'h4) begin
      miscompares++; $display("FAIL cd_pending: got %h expected 00000004", rd);
    end
  endtask

  task automatic test_id_wrap();
    logic [31:0] rd;
    bit seen;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      bus_read(JQ_ACQUIRE, 0, rd);
      vectors++;
      if (rd !== 32'(i)) begin
        miscompares++; $display("FAIL wrap_acquire%0d: got %h expected %h", i, rd, 32'(i));
      end
      bus_write(JQ_TRIGGER, 32'd0, 0);
      wait_start(seen);
      vectors++;
      if (!seen) begin
        miscompares++; $display("FAIL wrap_start%0d: got no start expected start", i);
      end
      pulse_done();
    end
    bus_read(JQ_ACQUIRE, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL wrap_id: got %h expected 00000000", rd);
    end
    bus_read(JQ_FINISHED, 1, rd);
    vectors++;
    if (rd !== 32'd256) begin
      miscompares++; $display("FAIL wrap_finished: got %h expected 00000100", rd);
    end
  endtask

  task automatic test_softclear();
    logic [31:0] rd;
    bit seen;
    do_reset();
    bus_read(JQ_ACQUIRE, 0, rd);
    bus_write(JQ_TRIGGER, 32'd0, 0);
    wait_start(seen);
    pulse_done();
    bus_read(JQ_ACQUIRE, 0, rd);
    bus_write(JQ_TRIGGER, 32'd0, 0);
    wait_start(seen);
    @(negedge clk);
    bus_write(JQ_SOFTCLEAR, 32'd5, 0);
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if (clear !== (k >= 2 && k <= 4)) begin
        miscompares++; $display("FAIL sc_window%0d: got %b expected %b", k, clear, (k >= 2 && k <= 4));
      end
      if (k == 2) begin
        req = 1'b1; wen = 1'b0; add = {27'd0, JQ_SOFTCLEAR, 2'b00}; id = 16'h0001; wdata = 32'd0;
      end
      if (k == 3) begin
        req = 1'b0; wen = 1'b1;
      end
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || run_ctx !== 2'd0 || wr_ctx !== 2'd0) begin
      miscompares++; $display("FAIL sc_state: got busy=%b rc=%0d wc=%0d expected 0/0/0", busy, run_ctx, wr_ctx);
    end
    bus_read(JQ_FINISHED, 0, rd);
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++; $display("FAIL sc_finished_kept: got %h expected 00000001", rd);
    end
    bus_read(JQ_ACQUIRE, 3, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL sc_jobid: got %h expected 00000000", rd);
    end
    bus_write(JQ_SOFTCLEAR, 32'd0, 0);
    repeat (6) @(negedge clk);
    bus_read(JQ_FINISHED, 0, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++; $display("FAIL sc_finished_cleared: got %h expected 00000000", rd);
    end
    bus_read(JQ_ACQUIRE, 5, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL sc_lock_released: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_swevt();
    bus_write(JQ_SWEVT, 32'd5, 0);
    vectors++;
    if (sw_evt !== 8'h20) begin
      miscompares++; $display("FAIL swevt_pulse: got %h expected 20", sw_evt);
    end
    @(negedge clk);
    vectors++;
    if (sw_evt !== 8'h00) begin
      miscompares++; $display("FAIL swevt_clear: got %h expected 00", sw_evt);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    bit seen;
    do_reset();
    bus_read(JQ_ACQUIRE, 2, rd);
    bus_write(JQ_TRIGGER, 32'd0, 2);
    wait_start(seen);
    evt_in = 3'b101;
    @(negedge clk);
    vectors++;
    if (evt !== 32'h0000_0A00) begin
      miscompares++; $display("FAIL aux_evt_route: got %h expected 00000a00", evt);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({clear, start, busy, r_valid, run_ctx, wr_ctx, evt, sw_evt} !== '0 || gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_reset: got clr=%b st=%b bsy=%b rv=%b rc=%0d wc=%0d evt=%h gnt=%b expected 0s gnt=1",
               clear, start, busy, r_valid, run_ctx, wr_ctx, evt, gnt);
    end
    evt_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (start !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midrun_no_restart: got start=%b busy=%b expected 0/0", start, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fifo_order();
    test_lock();
    test_commit_done();
    test_id_wrap();
    test_softclear();
    test_swevt();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
